fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage 8-bit core. It sits directly upstream of the decode stage.
- Owns the PC and drives the instruction-memory address. It selects the next PC from:
  - the sequential address,
  - a jump, call or branch target,
  - a return address held in an internal return-address stack (RAS).
- Applies hazard stalls and control-flow flushes. It presents a valid-qualified instruction and PC+1 to decode.

Parameters:
- ADDR_LEN, 12, PC / instruction-memory address width.
- INSTR_LEN, 19, instruction width.
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_LEN  instruction-memory address; combinationally equal to PC.
- imem_data  input  INSTR_LEN  instruction at imem_addr, combinational read.
- stall  input  1  hazard hold for PC and IF/ID.
- id_jump  input  1  decode has an absolute jump; target = id_instruction[11:0].
- id_call  input  1  decode has a call; same target as jump, pushes id_pc_plus1.
- id_ret  input  1  decode has a return; target = popped RAS entry.
- id_branch_taken  input  1  decode has a taken branch; target = id_pc_plus1 + sign-extended id_instruction[7:0].
- id_instruction  output  INSTR_LEN  IF/ID instruction.
- id_pc_plus1  output  ADDR_LEN  IF/ID PC+1.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- ras_overflow  output  1  sticky: a push was attempted while the RAS was full.
- ras_underflow  output  1  sticky: a pop was attempted while the RAS was empty.

Behaviour:
- Reset (rst=0, async) forces the following; all take effect immediately:
  - PC=0, id_instruction=0, id_pc_plus1=0, id_valid=0;
  - RAS pointer=0;
  - ras_overflow=0, ras_underflow=0.
- Redirect qualification: the four id_* redirect inputs are honoured only when id_valid=1 and stall=0.
- Redirect priority when several are asserted: ret > call > jump > branch.
- Per rising edge, the first matching case applies:
  - stall=1: PC, IF/ID and RAS hold. No push or pop occurs.
  - Qualified redirect:
    - PC ← target.
    - IF/ID ← bubble: instruction=0, pc_plus1=0, valid=0. This squashes the instruction fetched in the same cycle.
    - Redirect penalty: exactly 1 bubble.
  - Otherwise:
    - PC ← PC+1, wrapping 0xFFF→0x000.
    - id_instruction ← imem_data; id_pc_plus1 ← PC+1; id_valid ← 1.
- Branch arithmetic:
  - Offset is 8-bit two's complement, sign-extended to ADDR_LEN.
  - The sum is modulo 2^ADDR_LEN; wrap is silent.
- RAS is a LIFO of ADDR_LEN-bit entries with count 0..RAS_DEPTH.
  - Call: push id_pc_plus1, count+1.
  - Ret: pop top entry as target, count−1.
  - Push when count=RAS_DEPTH: jump still taken, nothing written, ras_overflow ← 1.
  - Pop when count=0: target = 0, count stays 0, ras_underflow ← 1.
  - Sticky flags clear only on reset.
- A bubble in IF/ID (id_valid=0) never triggers a redirect. This holds even if stale id_* inputs are high.
- The PC+1 value latched into IF/ID is the fetched instruction's own address + 1, not the next PC.
- Reset asserted mid-operation discards all state, including RAS contents. The first fetch after release is from address 0.

Test Plan:
- Reset release, IM[n]=0x10000+n, no control for 4 edges:
  - imem_addr goes 0,1,2,3,4.
  - id_instruction after edge k = 0x10000+k−1; id_pc_plus1 = k; id_valid=1 from edge 1.
- Hold stall=1 for 2 edges at PC=3: PC and IF/ID unchanged. On release, fetch resumes at 3 with no lost or duplicated instruction.
- Branch with id_pc_plus1=0x005, offset 0xFC, id_branch_taken=1:
  - next PC=0x001; id_valid=0 for 1 cycle.
  - Branch at id_pc_plus1=0xFFF, offset 0x02 → PC=0x001 (wrap).
- Call at id_pc_plus1=0x021 with target 0x100, then ret decoded later:
  - PC=0x100 after the call.
  - PC=0x021 after the ret.
  - RAS count returns to 0; both flags stay 0.
- RAS_DEPTH=8:
  - 9 nested calls: ras_overflow=1 after the 9th; the 9th return address is not stored.
  - 8 rets return the first 8 addresses in reverse order.
  - A further ret gives target 0 and ras_underflow=1.
- Priority and qualification:
  - id_ret=1 and id_jump=1 together → ret target wins.
  - Redirect inputs high while id_valid=0 → sequential fetch.
  - Redirect inputs high with stall=1 → hold, no RAS change.
  - Async reset pulse mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC/next-PC selection with return-address stack, hazard stall,
// redirect flush and IF/ID pipeline register.
module fetch_stage #(
  parameter int ADDR_LEN  = 12,
  parameter int INSTR_LEN = 19,
  parameter int RAS_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic [INSTR_LEN-1:0] imem_data,
  input  logic                 stall,
  input  logic                 id_jump,
  input  logic                 id_call,
  input  logic                 id_ret,
  input  logic                 id_branch_taken,
  output logic [INSTR_LEN-1:0] id_instruction,
  output logic [ADDR_LEN-1:0]  id_pc_plus1,
  output logic                 id_valid,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [ADDR_LEN-1:0] ONE = ADDR_LEN'(1);
  logic [ADDR_LEN-1:0]  pc_q, pc_d, pp1_q, pp1_d, tgt, pop_val;
  logic [INSTR_LEN-1:0] ins_q, ins_d;
  logic                 val_q, val_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic [ADDR_LEN-1:0]  ras_q [RAS_DEPTH];
  logic [PW-1:0]        top;
  logic                 go, redir, do_ret, do_call, push, empty, full;
  assign go      = val_q & ~stall;
  assign redir   = go & (id_ret | id_call | id_jump | id_branch_taken);
  assign do_ret  = go & id_ret;
  assign do_call = go & ~id_ret & id_call;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (PW+1)'(RAS_DEPTH);
  assign push    = do_call & ~full;
  assign top     = PW'(cnt_q - (PW+1)'(1));
  assign pop_val = empty ? '0 : ras_q[top];
  always_comb begin
    tgt   = do_ret ? pop_val
          : (id_call | id_jump) ? id_instruction[ADDR_LEN-1:0]
          : pp1_q + {{(ADDR_LEN-8){ins_q[7]}}, ins_q[7:0]};
    pc_d  = stall ? pc_q  : redir ? tgt : pc_q + ONE;
    ins_d = stall ? ins_q : redir ? '0  : imem_data;
    pp1_d = stall ? pp1_q : redir ? '0  : pc_q + ONE;
    val_d = stall ? val_q : ~redir;
    cnt_d = push ? cnt_q + (PW+1)'(1)
          : (do_ret & ~empty) ? cnt_q - (PW+1)'(1) : cnt_q;
    ovf_d = ovf_q | (do_call & full);
    unf_d = unf_q | (do_ret & empty);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      ins_q <= '0;
      pp1_q <= '0;
      val_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ins_q <= ins_d;
      pp1_q <= pp1_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Entries above the count are unreachable, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) ras_q[cnt_q[PW-1:0]] <= pp1_q;
  end
  assign imem_addr      = pc_q;
  assign id_instruction = ins_q;
  assign id_pc_plus1    = pp1_q;
  assign id_valid       = val_q;
  assign ras_overflow   = ovf_q;
  assign ras_underflow  = unf_q;
endmodule
